// File: rtl/data_mem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
//   memState : responder FSM states
//   memReq   : request fields captured on accept
//   LATENCY_MIN / LATENCY_MAX : legal range of the response latency
//   DATA_W   : width of one memory word
package data_mem_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } memState;

    typedef struct packed {
        logic              wr;
        logic [15:0]       addr;
        logic [DATA_W-1:0] wdata;
    } memReq;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for the data-memory responder.
// Ports:
//   clk   : clock; writes happen on the rising edge
//   we    : write enable
//   addr  : word index, shared by read and write
//   wdata : write data
//   rdata : asynchronous read data at addr
// Contents are never reset.
module mem_resp_array
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder. Accepts one load/store at a time over a
// valid/ready handshake and answers it exactly LATENCY cycles later with a
// single-cycle response pulse.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : request present
//   req_ready     : request can be accepted this cycle (not in WAIT)
//   req_wr        : 1 = store, 0 = load
//   req_addr      : byte address, word index = req_addr[ADDR_W:1]
//   req_wdata     : store data
//   resp_valid    : one-cycle response pulse
//   resp_wr       : echoes req_wr of the answered request
//   resp_rdata    : load data (0 for stores and misaligned requests)
//   resp_err      : answered request was misaligned (req_addr[0] = 1)
//   busy          : request accepted and not yet answered
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_wr,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    memState           state;
    logic [3:0]        cnt;
    memReq             req;

    logic              accept;
    logic              misaligned;
    logic              arrayWe;
    logic [ADDR_W-1:0] wordIdx;
    logic [DATA_W-1:0] arrayRdata;
    logic              unusedAddrBits;

    assign req_ready  = (state != WAIT);
    assign accept     = req_valid & req_ready;
    assign misaligned = req.addr[0];
    assign wordIdx    = req.addr[ADDR_W:1];

    // Address bits above the word index alias onto the array.
    assign unusedAddrBits = ^(req.addr >> (ADDR_W + 1));

    // Store commits at the edge ending RESP; a reset in that cycle drops it.
    assign arrayWe = (state == RESP) & req.wr & ~misaligned & ~rst;

    mem_resp_array #(
        .ADDR_W (ADDR_W)
    ) uArray (
        .clk   (clk),
        .we    (arrayWe),
        .addr  (wordIdx),
        .wdata (req.wdata),
        .rdata (arrayRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            req   <= '0;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        req   <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
                        cnt   <= CNT_LOAD;
                        state <= (LATENCY == LATENCY_MIN) ? RESP : WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response fields are forced to zero outside the RESP cycle.
    always_comb begin
        resp_valid = (state == RESP);
        resp_wr    = resp_valid & req.wr;
        resp_err   = resp_valid & misaligned;
        resp_rdata = '0;
        if (resp_valid && !req.wr && !misaligned) begin
            resp_rdata = arrayRdata;
        end
        busy = (state == WAIT);
    end

endmodule
